// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing defaults, coordinate/sync types and the raw sync decode.
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;
  localparam int unsigned H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int unsigned V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_bits_t;

  localparam sync_bits_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

  function automatic sync_bits_t sync_decode(
    input coord_t x, input coord_t y,
    input coord_t hs_lo, input coord_t hs_hi,
    input coord_t vs_lo, input coord_t vs_hi,
    input coord_t x_vis, input coord_t y_vis
  );
    sync_bits_t s;
    s.hs    = !((x >= hs_lo) && (x < hs_hi));
    s.vs    = !((y >= vs_lo) && (y < vs_hi));
    s.blank = (x < x_vis) && (y < y_vis);
    return s;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster/sync bundle from the timing generator to the renderers.
// frame_count exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic   pixel_clk;
  logic   hs;
  logic   vs;
  logic   blank;
  logic   sync;
  coord_t DrawX;
  coord_t DrawY;
  logic   frame_start;
  logic   line_start;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_count;
`endif

  modport master (
`ifdef VGA_FRAME_CNT_EN
    output frame_count,
`endif
    output pixel_clk, hs, vs, blank, sync, DrawX, DrawY, frame_start, line_start
  );

  modport slave (
`ifdef VGA_FRAME_CNT_EN
    input frame_count,
`endif
    input pixel_clk, hs, vs, blank, sync, DrawX, DrawY, frame_start, line_start
  );

endinterface

// File: rtl/vga_sync_delay.sv
// Shift line of sync bits, advanced once per pixel; reset loads the inactive pattern.
module vga_sync_delay
  import vga_timing_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       vga_clk,
  input  logic       rst,
  input  logic       advance,
  input  sync_bits_t sync_in,
  output sync_bits_t sync_out
);

  sync_bits_t line_q [DEPTH];

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) line_q[i] <= SYNC_IDLE;
    end else if (advance) begin
      line_q[0] <= sync_in;
      for (int unsigned i = 1; i < DEPTH; i++) line_q[i] <= line_q[i-1];
    end
  end

  assign sync_out = line_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, pixel clock, delayed hs/vs/blank and wrap pulses.
// Define VGA_FRAME_CNT_EN to add the 8-bit frame_count output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT    = H_FRONT_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BACK     = H_BACK_DEF,
  parameter int unsigned V_VISIBLE  = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT    = V_FRONT_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BACK     = V_BACK_DEF,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  vga_timing_gen_if.master   vga
);

  localparam coord_t X_LAST = coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam coord_t Y_LAST = coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam coord_t HS_LO  = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_HI  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_LO  = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_HI  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam coord_t X_VIS  = coord_t'(H_VISIBLE);
  localparam coord_t Y_VIS  = coord_t'(V_VISIBLE);
  localparam int unsigned DL_DEPTH = (SYNC_DELAY == 0) ? 1 : SYNC_DELAY;

  logic       pix_q;
  coord_t     x_q, y_q, x_next, y_next;
  logic       line_q, frame_q;
  logic       advance, x_last, y_last;
  sync_bits_t dl_in, dl_out;

  assign advance = pix_q;
  assign x_last  = (x_q == X_LAST);
  assign y_last  = (y_q == Y_LAST);

  always_comb begin
    x_next = x_q;
    y_next = y_q;
    if (x_last) begin
      x_next = '0;
      y_next = y_last ? '0 : y_q + coord_t'(1);
    end else begin
      x_next = x_q + coord_t'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pix_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      pix_q   <= ~pix_q;
      line_q  <= advance && x_last;
      frame_q <= advance && x_last && y_last;
      if (advance) begin
        x_q <= x_next;
        y_q <= y_next;
      end
    end
  end

  // Zero delay registers the decode of the upcoming coordinate once; otherwise the
  // present coordinate's decode enters an N-deep line so the output lags N pixels.
  assign dl_in = (SYNC_DELAY == 0)
               ? sync_decode(x_next, y_next, HS_LO, HS_HI, VS_LO, VS_HI, X_VIS, Y_VIS)
               : sync_decode(x_q, y_q, HS_LO, HS_HI, VS_LO, VS_HI, X_VIS, Y_VIS);

  vga_sync_delay #(.DEPTH(DL_DEPTH)) u_sync_delay (
    .vga_clk  (Clk),
    .rst      (Reset),
    .advance  (advance),
    .sync_in  (dl_in),
    .sync_out (dl_out)
  );

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                            frame_cnt_q <= '0;
    else if (advance && x_last && y_last) frame_cnt_q <= frame_cnt_q + 8'd1;
  end

  assign vga.frame_count = frame_cnt_q;
`endif

  assign vga.pixel_clk   = pix_q;
  assign vga.DrawX       = x_q;
  assign vga.DrawY       = y_q;
  assign vga.hs          = dl_out.hs;
  assign vga.vs          = dl_out.vs;
  assign vga.blank       = dl_out.blank;
  assign vga.sync        = 1'b0;
  assign vga.line_start  = line_q;
  assign vga.frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster, SYNC_DELAY 0 and 2 side by side.
module tb_vga_timing_gen;

  localparam int unsigned HV = 16, HF = 4, HS = 6, HB = 6;
  localparam int unsigned VV = 8,  VF = 2, VS = 2, VB = 3;
  localparam int unsigned HT = HV + HF + HS + HB;
  localparam int unsigned VT = VV + VF + VS + VB;

  typedef struct packed {
    logic       pclk;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       ls;
    logic       fs;
    logic       sync;
  } obs_t;

  typedef struct {
    int unsigned k;
    obs_t        d0;
    logic        d2_hs;
    logic        d2_vs;
    logic        d2_blank;
  } vec_t;

  localparam obs_t RST_OBS = '{pclk: 1'b0, x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1,
                               blank: 1'b0, ls: 1'b0, fs: 1'b0, sync: 1'b0};

  logic        Clk   = 1'b0;
  logic        Reset = 1'b1;
  int unsigned k     = 0;
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          mon_en  = 1'b0;
  vec_t        tbl[$];
  obs_t        o0, o2;

  always #5 Clk = ~Clk;

  // Clk edges since reset release: the model's only notion of time.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) k <= 0;
    else       k <= k + 1;
  end

  vga_timing_gen_if vif0();
  vga_timing_gen_if vif2();

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_DELAY(0)
  ) dut0 (.Clk(Clk), .Reset(Reset), .vga(vif0));

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_DELAY(2)
  ) dut2 (.Clk(Clk), .Reset(Reset), .vga(vif2));

  assign o0 = {vif0.pixel_clk, vif0.DrawX, vif0.DrawY, vif0.hs, vif0.vs, vif0.blank,
               vif0.line_start, vif0.frame_start, vif0.sync};
  assign o2 = {vif2.pixel_clk, vif2.DrawX, vif2.DrawY, vif2.hs, vif2.vs, vif2.blank,
               vif2.line_start, vif2.frame_start, vif2.sync};

  // Pixel index n = k/2 since release; sync outputs show pixel n-dly (idle before that).
  function automatic obs_t model(input int unsigned kk, input int unsigned dly);
    obs_t        o;
    int unsigned n, m, mx, my, lag;
    n   = kk / 2;
    lag = (dly == 0) ? 1 : dly;
    o       = RST_OBS;
    o.pclk  = (kk % 2) == 1;
    o.x     = 10'(n % HT);
    o.y     = 10'((n / HT) % VT);
    if (n >= lag) begin
      m  = n - dly;
      mx = m % HT;
      my = (m / HT) % VT;
      o.hs    = !(mx >= HV + HF && mx < HV + HF + HS);
      o.vs    = !(my >= VV + VF && my < VV + VF + VS);
      o.blank = (mx < HV) && (my < VV);
    end
    o.ls = (kk % 2 == 0) && (n > 0) && (n % HT == 0);
    o.fs = (kk % 2 == 0) && (n > 0) && (n % (HT * VT) == 0);
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("pclk=%b x=%0d y=%0d hs=%b vs=%b blank=%b ls=%b fs=%b sync=%b",
                     o.pclk, o.x, o.y, o.hs, o.vs, o.blank, o.ls, o.fs, o.sync);
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d got {%s} required {%s}", name, k, fmt(got), fmt(exp));
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s k=%0d got %0d required %0d", name, k, got, exp);
    end
  endtask

  task automatic add(input int unsigned kk, input logic pc, input int unsigned x, input int unsigned y,
                     input logic hs, input logic vs, input logic bl, input logic ls, input logic fs,
                     input logic dhs, input logic dvs, input logic dbl);
    vec_t v;
    v.k  = kk;
    v.d0 = '{pclk: pc, x: 10'(x), y: 10'(y), hs: hs, vs: vs, blank: bl, ls: ls, fs: fs, sync: 1'b0};
    v.d2_hs = dhs; v.d2_vs = dvs; v.d2_blank = dbl;
    tbl.push_back(v);
  endtask

  task automatic run_to(input int unsigned target);
    int guard = 0;
    while (k != target && guard < 5000) begin
      @(negedge Clk);
      guard++;
    end
    if (k != target) check_int("run_to_timeout", int'(k), int'(target));
  endtask

  task automatic do_reset(input int cycles);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (cycles) @(negedge Clk);
    Reset = 1'b0;
  endtask

  always @(negedge Clk) begin
    if (mon_en) begin
      check("mon_d0", o0, model(k, 0));
      check("mon_d2", o2, model(k, 2));
`ifdef VGA_FRAME_CNT_EN
      check_int("mon_frame_count", int'(vif0.frame_count), int'(((k / 2) / (HT * VT)) % 256));
`endif
    end
  end

  initial begin
    //   k    pc  x   y  hs vs bl ls fs | d2: hs vs bl
    add(0,   0,  0,  0, 1, 1, 0, 0, 0,   1, 1, 0);
    add(1,   1,  0,  0, 1, 1, 0, 0, 0,   1, 1, 0);
    add(2,   0,  1,  0, 1, 1, 1, 0, 0,   1, 1, 0);
    add(4,   0,  2,  0, 1, 1, 1, 0, 0,   1, 1, 1);
    add(32,  0, 16,  0, 1, 1, 0, 0, 0,   1, 1, 1);
    add(36,  0, 18,  0, 1, 1, 0, 0, 0,   1, 1, 0);
    add(40,  0, 20,  0, 0, 1, 0, 0, 0,   1, 1, 0);
    add(44,  0, 22,  0, 0, 1, 0, 0, 0,   0, 1, 0);
    add(52,  0, 26,  0, 1, 1, 0, 0, 0,   0, 1, 0);
    add(56,  0, 28,  0, 1, 1, 0, 0, 0,   1, 1, 0);
    add(64,  0,  0,  1, 1, 1, 1, 1, 0,   1, 1, 0);
    add(65,  1,  0,  1, 1, 1, 1, 0, 0,   1, 1, 0);
    add(640, 0,  0, 10, 1, 0, 0, 1, 0,   1, 1, 0);
    add(644, 0,  2, 10, 1, 0, 0, 0, 0,   1, 0, 0);
    add(768, 0,  0, 12, 1, 1, 0, 1, 0,   1, 0, 0);
    add(960, 0,  0,  0, 1, 1, 1, 1, 1,   1, 1, 0);
    add(961, 1,  0,  0, 1, 1, 1, 0, 0,   1, 1, 0);

    Reset = 1'b1;
    repeat (5) @(negedge Clk);
    check("reset_hold_d0", o0, RST_OBS);
    check("reset_hold_d2", o2, RST_OBS);
    Reset  = 1'b0;
    mon_en = 1'b1;

    foreach (tbl[i]) begin
      obs_t e2;
      run_to(tbl[i].k);
      e2 = tbl[i].d0;
      e2.hs = tbl[i].d2_hs; e2.vs = tbl[i].d2_vs; e2.blank = tbl[i].d2_blank;
      check($sformatf("tbl_d0[%0d]", i), o0, tbl[i].d0);
      check($sformatf("tbl_d2[%0d]", i), o2, e2);
    end

    // Reset in the middle of an hs pulse, then confirm a clean restart of line 0.
    do_reset(2);
    run_to(5 * HT * 2 + 22 * 2);
    check_int("mid_pre_hs", int'(vif0.hs), 0);
    #1 Reset = 1'b1;
    #1;
    check("mid_async_d0", o0, RST_OBS);
    check("mid_async_d2", o2, RST_OBS);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    begin
      int guard = 0;
      int low_len = 0;
      while (vif0.hs !== 1'b0 && guard < 400) begin
        @(negedge Clk);
        guard++;
      end
      check_int("hs_restart_x", int'(vif0.DrawX), HV + HF);
      check_int("hs_restart_y", int'(vif0.DrawY), 0);
      guard = 0;
      while (vif0.hs === 1'b0 && guard < 400) begin
        low_len++;
        @(negedge Clk);
        guard++;
      end
      check_int("hs_low_clks", low_len, 2 * HS);
    end

    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(40, 1200)) @(negedge Clk);
      #($urandom_range(1, 3)) Reset = 1'b1;
      #1;
      check("rnd_async_d0", o0, RST_OBS);
      check("rnd_async_d2", o2, RST_OBS);
      repeat ($urandom_range(1, 3)) @(negedge Clk);
      Reset = 1'b0;
    end
    repeat (1000) @(negedge Clk);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
